// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: instruction width,
// PC step and fetch FSM state encodings.
package inst_fetch_pkg;

  localparam int unsigned INSTRUCTION_WIDTH = 32;
  localparam int unsigned PC_INC            = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_buf.sv
// fetch_buf: small synchronous FIFO with push/pop/flush, occupancy count
// and a zero-gated head word. DEPTH must be a power of two (>= 2).
module fetch_buf #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Qualify push/pop against occupancy; a full buffer may still accept a
  // push when the head leaves in the same cycle.
  always_comb begin
    do_pop     = pop && (count != '0);
    do_push    = push && ((count != FULL) || do_pop);
    head_valid = (count != '0);
    head_data  = head_valid ? mem[rd_ptr] : '0;
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are only observed through the count-gated head.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: owns the PC, issues single-outstanding word reads over a
// req/gnt + rvalid interface, buffers returned words in fetch_buf and
// presents them to decode with valid/ready. Redirects flush the buffer and
// drop at most one stale response.
// Optional feature macro: FETCH_ILLEGAL_CHK_EN (adds inst_illegal output).
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned          PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter int unsigned          BUF_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          imem_req,
  output logic [PC_WIDTH-1:0]           imem_addr,
  input  logic                          imem_gnt,
  input  logic                          imem_rvalid,
  input  logic [INSTRUCTION_WIDTH-1:0]  imem_rdata,
  output logic                          inst_valid,
  output logic [INSTRUCTION_WIDTH-1:0]  inst,
  output logic [PC_WIDTH-1:0]           inst_pc,
`ifdef FETCH_ILLEGAL_CHK_EN
  output logic                          inst_illegal,
`endif
  input  logic                          inst_ready,
  input  logic                          redirect_valid,
  input  logic [PC_WIDTH-1:0]           redirect_pc
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
`ifdef FETCH_ILLEGAL_CHK_EN
  localparam int unsigned EW = INSTRUCTION_WIDTH + PC_WIDTH + 1;
`else
  localparam int unsigned EW = INSTRUCTION_WIDTH + PC_WIDTH;
`endif

  fetch_state_t          state;
  logic [PC_WIDTH-1:0]   fetch_pc;
  logic                  drop;
  logic [CW-1:0]         buf_count;
  logic [CW-1:0]         count_after;
  logic                  has_space;
  logic                  push;
  logic                  pop;
  logic [EW-1:0]         push_data;
  logic [EW-1:0]         head_data;
  logic [PC_WIDTH-1:0]   redirect_al;

  // Buffer handshakes and the space check used when choosing the next
  // request. A slot is reserved at grant, so WAIT never sees a full buffer.
  always_comb begin
    redirect_al = redirect_pc & ~(PC_WIDTH'(2'b11));
    push        = (state == WAIT) && imem_rvalid && !drop && !redirect_valid;
    pop         = inst_valid && inst_ready && !redirect_valid;
    count_after = buf_count + CW'(push) - CW'(pop);
    has_space   = redirect_valid || (count_after < FULL);
`ifdef FETCH_ILLEGAL_CHK_EN
    push_data   = {(imem_rdata[1:0] != 2'b11), imem_rdata, imem_addr};
`else
    push_data   = {imem_rdata, imem_addr};
`endif
  end

  // Fetch FSM with registered request outputs; redirect takes priority.
  // A redirect in REQ keeps the request on the bus until granted and marks
  // its response stale via drop, so address stability is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      drop      <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_al;
      case (state)
        IDLE: begin
          state     <= REQ;
          imem_req  <= 1'b1;
          imem_addr <= redirect_al;
        end
        REQ: begin
          drop <= 1'b1;
          if (imem_gnt) begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            drop      <= 1'b0;
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= redirect_al;
          end else begin
            drop <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (has_space) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (imem_gnt) begin
            state    <= WAIT;
            imem_req <= 1'b0;
            if (!drop) fetch_pc <= fetch_pc + PC_WIDTH'(PC_INC);
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            drop <= 1'b0;
            if (has_space) begin
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= fetch_pc;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (EW)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (buf_count),
    .head_valid (inst_valid),
    .head_data  (head_data)
  );

  // Unpack the buffer head toward decode.
  always_comb begin
`ifdef FETCH_ILLEGAL_CHK_EN
    {inst_illegal, inst, inst_pc} = head_data;
`else
    {inst, inst_pc} = head_data;
`endif
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a memory model answers req/gnt/rvalid,
// expected {inst, pc} entries are queued at grant and compared on each pop.
module tb_inst_fetch;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_ILLEGAL_CHK_EN
  logic        inst_illegal;
`endif

  // stimulus intent
  logic        ready_i;
  logic        redir_i;
  logic [31:0] redir_pc_i;
  int unsigned gnt_delay;
  int unsigned resp_delay;
  logic        spurious_en;

  // memory model and scoreboard state
  logic        resp_pending;
  int unsigned resp_left;
  logic [31:0] resp_addr;
  int unsigned req_age;
  logic        stale;
  logic [31:0] exp_fetch;
  exp_t        sb_q[$];

  int unsigned tests_run;
  int unsigned tests_failed;
  int unsigned pops;
  int unsigned grants;
  logic [31:0] last_gnt_addr;
  logic [31:0] last_pop_pc;

  inst_fetch #(
    .PC_WIDTH  (32),
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
`ifdef FETCH_ILLEGAL_CHK_EN
    .inst_illegal   (inst_illegal),
`endif
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0300) return 32'h0000_0001;
    if (a == 32'h0000_0304) return 32'h0000_0033;
    return {a[23:0], 8'h13};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample DUT at negedge, drive memory/decode inputs for
  // the coming edge, and update the scoreboard with what that edge will do.
  task automatic step();
    logic g;
    logic rv;
    exp_t e;
    @(negedge clk);
    rv = 1'b0;
    if (resp_pending) begin
      resp_left--;
      if (resp_left == 0) begin
        rv = 1'b1;
        resp_pending = 1'b0;
      end
    end
    g = imem_req && (req_age >= gnt_delay);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(resp_addr) : $urandom();
    if (!rv && spurious_en && imem_req && !resp_pending && ($urandom_range(0, 3) == 0))
      imem_rvalid = 1'b1;
    imem_gnt = g;
    if (!g && spurious_en && !imem_req && ($urandom_range(0, 3) == 0))
      imem_gnt = 1'b1;
    if (imem_req) req_age = g ? 0 : req_age + 1;
    if (g) begin
      resp_pending  = 1'b1;
      resp_left     = resp_delay;
      resp_addr     = imem_addr;
      grants++;
      last_gnt_addr = imem_addr;
      if (stale) begin
        stale = 1'b0;
      end else begin
        check_eq("gnt_addr", imem_addr, exp_fetch);
        e.inst = mem_word(imem_addr);
        e.pc   = imem_addr;
        sb_q.push_back(e);
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    inst_ready     = ready_i;
    redirect_valid = redir_i;
    redirect_pc    = redir_pc_i;
    if (inst_valid && ready_i && !redir_i) begin
      check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("inst", inst, e.inst);
        check_eq("inst_pc", inst_pc, e.pc);
`ifdef FETCH_ILLEGAL_CHK_EN
        check_eq("inst_illegal", inst_illegal, (e.inst[1:0] != 2'b11));
`endif
      end
      pops++;
      last_pop_pc = inst_pc;
    end
    if (redir_i) begin
      if (imem_req && !g) stale = 1'b1;
      sb_q.delete();
      exp_fetch = redir_pc_i & ~32'd3;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ready_i        = 1'b0;
    redir_i        = 1'b0;
    redir_pc_i     = '0;
    gnt_delay      = 0;
    resp_delay     = 1;
    spurious_en    = 1'b0;
    resp_pending   = 1'b0;
    resp_left      = 0;
    req_age        = 0;
    stale          = 1'b0;
    exp_fetch      = 32'h0000_0000;
    grants         = 0;
    sb_q.delete();
    @(negedge clk);
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_valid", inst_valid, 1'b0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_inst_pc", inst_pc, 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic wait_pops(input int unsigned n, input int unsigned budget);
    int unsigned target;
    target = pops + n;
    for (int unsigned i = 0; i < budget && pops < target; i++) step();
    check_eq("wait_pops", pops, target);
  endtask

  task automatic wait_grants(input int unsigned n, input int unsigned budget);
    for (int unsigned i = 0; i < budget && grants < n; i++) step();
    check_eq("wait_grants", grants, n);
  endtask

  task automatic redirect_step(input logic [31:0] pc);
    redir_i    = 1'b1;
    redir_pc_i = pc;
    step();
    redir_i    = 1'b0;
  endtask

  initial begin
    int unsigned p0;
    int unsigned g0;
    logic [31:0] held;
    tests_run    = 0;
    tests_failed = 0;
    pops         = 0;
    rst_n        = 1'b0;

    // Streaming with a 1-cycle memory and decode always ready.
    do_reset();
    ready_i = 1'b1;
    step();
    check_eq("req_latency", imem_req, 1'b1);
    check_eq("first_addr", imem_addr, 32'h0);
    step();
    check_eq("valid_before_push", inst_valid, 1'b0);
    step();
    check_eq("valid_latency", inst_valid, 1'b1);
    p0 = pops;
    repeat (20) step();
    check_eq("throughput", pops - p0, 10);

    // Decode stalled: buffer fills to depth and the request stops.
    do_reset();
    repeat (10) step();
    check_eq("stall_req", imem_req, 1'b0);
    check_eq("stall_valid", inst_valid, 1'b1);
    check_eq("stall_grants", grants, 2);
    ready_i = 1'b1;
    wait_pops(2, 20);
    check_eq("stall_last_pc", last_pop_pc, 32'h4);
    wait_grants(3, 20);
    check_eq("resume_addr", last_gnt_addr, 32'h8);

    // Redirect in WAIT coinciding with rvalid.
    do_reset();
    ready_i = 1'b1;
    wait_grants(3, 20);
    check_eq("wait_gnt8", last_gnt_addr, 32'h8);
    redirect_step(32'h100);
    wait_pops(1, 30);
    check_eq("redir_pc0", last_pop_pc, 32'h100);
    wait_pops(1, 30);
    check_eq("redir_pc1", last_pop_pc, 32'h104);

    // Redirect in WAIT before rvalid, then a back-to-back redirect.
    do_reset();
    ready_i    = 1'b1;
    resp_delay = 3;
    wait_grants(3, 40);
    redirect_step(32'h100);
    redirect_step(32'h180);
    wait_pops(1, 40);
    check_eq("b2b_pc0", last_pop_pc, 32'h180);
    wait_pops(1, 40);
    check_eq("b2b_pc1", last_pop_pc, 32'h184);

    // Redirect while a request waits 3 cycles for grant.
    do_reset();
    ready_i   = 1'b1;
    gnt_delay = 3;
    step();
    check_eq("req_pending", imem_req, 1'b1);
    held = imem_addr;
    redirect_step(32'h200);
    g0 = grants;
    for (int i = 0; i < 10 && grants == g0; i++) begin
      step();
      check_eq("addr_stable", imem_addr, held);
      check_eq("req_held", imem_req, 1'b1);
    end
    wait_pops(1, 40);
    check_eq("redir_req_pc", last_pop_pc, 32'h200);

    // Unaligned redirect near the top of memory, fill, then drain across wrap.
    do_reset();
    redir_i    = 1'b1;
    redir_pc_i = 32'hFFFF_FFF7;
    step();
    redir_i = 1'b0;
    repeat (12) step();
    check_eq("full_req", imem_req, 1'b0);
    ready_i = 1'b1;
    wait_pops(3, 30);
    check_eq("pre_wrap_pc", last_pop_pc, 32'hFFFF_FFFC);
    wait_pops(1, 30);
    check_eq("wrap_pc", last_pop_pc, 32'h0);
    for (int i = 0; i < 60; i++) begin
      ready_i = 1'($urandom_range(0, 1));
      step();
    end

    // Instruction encoding check words.
    do_reset();
    ready_i    = 1'b1;
    redir_i    = 1'b1;
    redir_pc_i = 32'h300;
    step();
    redir_i = 1'b0;
    wait_pops(2, 30);
    check_eq("enc_last_pc", last_pop_pc, 32'h304);

    // Random stress with spurious gnt/rvalid and occasional redirects.
    do_reset();
    spurious_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ready_i    = 1'($urandom_range(0, 1));
      gnt_delay  = $urandom_range(0, 2);
      resp_delay = $urandom_range(1, 3);
      redir_i    = ($urandom_range(0, 15) == 0);
      redir_pc_i = $urandom();
      step();
    end
    redir_i = 1'b0;

    // Reset in the middle of traffic, then recover from RESET_PC.
    do_reset();
    ready_i = 1'b1;
    wait_pops(2, 40);
    check_eq("recover_pc", last_pop_pc, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch unit that produces the instruction word consumed by the decode/control stage of the single-cycle core.
- Owns the PC and issues word-aligned reads to instruction memory over a req/gnt + rvalid interface, with at most one read outstanding.
- Buffers returned words in a small FIFO and presents them downstream with a valid/ready handshake.
- Supports redirect (branch/jump/trap) with discard of stale in-flight data.

Parameters:
- PC_WIDTH, 32, width of PC and memory address.
- RESET_PC, 32'h0000_0000, first fetch address after reset; low 2 bits must be 0.
- BUF_DEPTH, 2, instruction buffer entries (power of 2, >=2).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  read request; held until imem_gnt.
- imem_addr  out  PC_WIDTH  read address; stable while imem_req=1.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; at least 1 cycle after gnt.
- imem_rdata  in  INSTRUCTION_WIDTH  returned instruction word.
- inst_valid  out  1  buffer head valid.
- inst  out  INSTRUCTION_WIDTH  head instruction to decode/control.
- inst_pc  out  PC_WIDTH  PC of head instruction.
- inst_ready  in  1  decode accepts head; pop on inst_valid & inst_ready.
- redirect_valid  in  1  single-cycle redirect strobe.
- redirect_pc  in  PC_WIDTH  new fetch PC; bits [1:0] forced to 0.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc=RESET_PC; state IDLE; imem_req=0; imem_addr=RESET_PC.
  - Buffer empty; inst_valid=0; inst=0; inst_pc=0; drop=0.
- All outputs are registered except inst_valid, inst and inst_pc, which come directly from the buffer head.
- States:
  - IDLE: imem_req=0. If (buffer count + in-flight) < BUF_DEPTH, go to REQ next cycle, driving imem_req=1 and imem_addr=fetch_pc.
  - REQ: imem_req=1 with imem_addr held stable. On imem_gnt, fetch_pc += 4 (modulo 2^PC_WIDTH, so the PC wraps to 0) and go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid:
    - if drop=0, push {imem_rdata, address} into the buffer; if drop=1, discard and clear drop;
    - then go to REQ if space remains, otherwise IDLE.
- A buffer slot is reserved at grant, so a push never overflows.
- Push and pop in the same cycle are both honoured, including when the buffer is full or holds one entry.
- Latency: first imem_req is high in the 2nd cycle after reset release. With a 1-cycle memory, inst_valid rises 1 cycle after imem_rvalid.
- Maximum throughput is one instruction per 2 cycles (single outstanding read).
- imem_rvalid outside WAIT is ignored.
- imem_gnt outside REQ is ignored.
- Redirect has highest priority and takes effect in the same cycle as the strobe:
  - Buffer flushed, so inst_valid=0 next cycle; a pop in the same cycle is discarded.
  - fetch_pc=redirect_pc, and it does not increment for the old request.
  - In IDLE: go to REQ next cycle with the new address.
  - In REQ without gnt: the pending request completes unchanged (address stability); go to WAIT with drop=1. If gnt arrives in the same cycle, behaviour is identical.
  - In WAIT: set drop=1. If rvalid arrives in the same cycle, that data is discarded and drop stays 0.
  - Back-to-back redirects: the last one wins; only one response is ever dropped.
- Reset mid-transaction: all state cleared immediately. The memory side must also be reset.

Optional Feature:
- Macro FETCH_ILLEGAL_CHK_EN.
- When defined: an extra 1-bit buffer field and output port inst_illegal (out, 1). It is set when imem_rdata[1:0] != 2'b11 (non-32-bit encoding) and accompanies the head entry.
- When undefined: no port and no field. The word is passed unchanged; decode treats it as invalid and drives all-zero controls.

Decomposition:
- Shared header: INSTRUCTION_WIDTH, the PC increment constant (4), and state encodings IDLE/REQ/WAIT.
- One sub-module, fetch_buf: synchronous FIFO (push/pop/flush, count, head data) parameterised by depth and data width.

Test Plan:
- Reset, 1-cycle memory, inst_ready=1 → imem_addr sequence 0x0,0x4,0x8; inst/inst_pc pairs match memory contents; no gaps beyond 1 instruction per 2 cycles.
- inst_ready=0 for 10 cycles → exactly BUF_DEPTH=2 entries held, imem_req low; on release, entries 0x0,0x4 pop in order, then fetch resumes at 0x8.
- Redirect to 0x100 during WAIT for 0x8 → 0x8 data discarded; next inst_pc=0x100, then 0x104.
- Redirect to 0x200 in REQ with gnt delayed 3 cycles → imem_addr stays stable until gnt; that response is dropped; next request is at 0x200.
- Simultaneous push and pop with buffer full, plus fetch_pc=0xFFFF_FFFC → no overflow or loss; next address wraps to 0x0.
- FETCH_ILLEGAL_CHK_EN defined, rdata=32'h0000_0001 → inst_illegal=1; rdata=32'h0000_0033 → inst_illegal=0.
